// File: rtl/decode_sequencer.sv
// Fetch-to-execute decode sequencer: 2-entry skid FIFO with opcode-to-immediate-format classification.
// Optional stall counter enabled by defining DECODE_STALL_CNT_EN.
module decode_sequencer #(
   parameter int unsigned PC_W  = 32,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             nrst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      inst_in,
   input  logic [PC_W-1:0]  pc_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      inst_out,
   output logic [PC_W-1:0]  pc_out,
   output logic [2:0]       imm_type,
   output logic             illegal,
   output logic [CNT_W-1:0] stall_cnt
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t state;

   // Second (non-head) entry; only meaningful in FULL.
   logic [31:0]     sk_inst;
   logic [PC_W-1:0] sk_pc;
   logic [2:0]      sk_type;
   logic            sk_ill;

   logic [2:0] new_type;
   logic       new_ill;
   logic       push;
   logic       pop;

   always_comb begin
      new_type = '0;
      new_ill  = 1'b0;
      unique case (inst_in[6:0])
         7'b0000011, 7'b0010011, 7'b1100111,
         7'b1110011, 7'b0001111:              new_type = 3'd1;
         7'b0100011:                          new_type = 3'd2;
         7'b1100011:                          new_type = 3'd3;
         7'b1101111:                          new_type = 3'd4;
         7'b0110111, 7'b0010111:              new_type = 3'd5;
         7'b0110011:                          new_type = 3'd0;
         default:                             new_ill  = 1'b1;
      endcase
   end

   assign in_ready  = (state != FULL);
   assign out_valid = (state != EMPTY);
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state    <= EMPTY;
         inst_out <= '0;
         pc_out   <= '0;
         imm_type <= '0;
         illegal  <= 1'b0;
         sk_inst  <= '0;
         sk_pc    <= '0;
         sk_type  <= '0;
         sk_ill   <= 1'b0;
      end else if (flush) begin
         state <= EMPTY;
      end else begin
         unique case (state)
            EMPTY: begin
               if (push) begin
                  inst_out <= inst_in;
                  pc_out   <= pc_in;
                  imm_type <= new_type;
                  illegal  <= new_ill;
                  state    <= ONE;
               end
            end
            ONE: begin
               if (push && pop) begin
                  inst_out <= inst_in;
                  pc_out   <= pc_in;
                  imm_type <= new_type;
                  illegal  <= new_ill;
               end else if (push) begin
                  sk_inst <= inst_in;
                  sk_pc   <= pc_in;
                  sk_type <= new_type;
                  sk_ill  <= new_ill;
                  state   <= FULL;
               end else if (pop) begin
                  state <= EMPTY;
               end
            end
            FULL: begin
               if (pop) begin
                  inst_out <= sk_inst;
                  pc_out   <= sk_pc;
                  imm_type <= sk_type;
                  illegal  <= sk_ill;
                  state    <= ONE;
               end
            end
            default: state <= EMPTY;
         endcase
      end
   end

`ifdef DECODE_STALL_CNT_EN
   // Saturating; deliberately not cleared by flush.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         stall_cnt <= '0;
      end else if (out_valid && !out_ready && (stall_cnt != '1)) begin
         stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end
`else
   assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_decode_sequencer.sv
// Self-checking bench for decode_sequencer: directed test-plan steps followed by random
// traffic, all compared against a queue-based reference model.
module tb_decode_sequencer;

   localparam int PC_W  = 32;
   localparam int CNT_W = 16;

   logic             clk = 1'b0;
   logic             nrst = 1'b1;
   logic             flush = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [31:0]      inst_in = '0;
   logic [PC_W-1:0]  pc_in = '0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [31:0]      inst_out;
   logic [PC_W-1:0]  pc_out;
   logic [2:0]       imm_type;
   logic             illegal;
   logic [CNT_W-1:0] stall_cnt;

   decode_sequencer #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .nrst(nrst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .inst_in(inst_in), .pc_in(pc_in),
      .out_valid(out_valid), .out_ready(out_ready), .inst_out(inst_out), .pc_out(pc_out),
      .imm_type(imm_type), .illegal(illegal), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] inst;
      logic [31:0] pc;
      int          ty;
      bit          ill;
   } ent_t;

   ent_t        q[$];
   int          fmt[bit [6:0]];
   longint      stall_m;
   int          passed = 0;
   int          failed = 0;
   int          total  = 0;
   bit [6:0]    ops[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) begin
         passed++;
      end else begin
         failed++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive inputs, compare outputs with the model, advance model and clock.
   task automatic step(input bit iv, input logic [31:0] ins, input logic [31:0] pc,
                       input bit ordy, input bit fl);
      ent_t e;
      bit rdy, vld, push, pop;
      bit [6:0] op;
      in_valid  = iv;
      inst_in   = ins;
      pc_in     = pc;
      out_ready = ordy;
      flush     = fl;
      #1;
      rdy = (q.size() < 2);
      vld = (q.size() > 0);
      chk("in_ready", {31'd0, in_ready}, {31'd0, rdy});
      chk("out_valid", {31'd0, out_valid}, {31'd0, vld});
`ifdef DECODE_STALL_CNT_EN
      chk("stall_cnt", 32'(stall_cnt), 32'(stall_m));
`else
      chk("stall_cnt", 32'(stall_cnt), 32'd0);
`endif
      if (vld) begin
         chk("inst_out", inst_out, q[0].inst);
         chk("pc_out", pc_out, q[0].pc);
         chk("imm_type", 32'(imm_type), 32'(q[0].ty));
         chk("illegal", {31'd0, illegal}, {31'd0, q[0].ill});
      end
      push = iv && rdy;
      pop  = vld && ordy;
      if (vld && !ordy && stall_m != (64'd1 << CNT_W) - 1) stall_m++;
      op    = ins[6:0];
      e.inst = ins;
      e.pc   = pc;
      if (fmt.exists(op)) begin
         e.ty  = fmt[op];
         e.ill = 1'b0;
      end else begin
         e.ty  = 0;
         e.ill = 1'b1;
      end
      if (fl) begin
         q.delete();
      end else begin
         if (pop) q.delete(0);
         if (push) q.push_back(e);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      in_valid  = 1'b0;
      out_ready = 1'b0;
      flush     = 1'b0;
      nrst      = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_inst_out", inst_out, 32'd0);
      chk("rst_pc_out", pc_out, 32'd0);
      chk("rst_imm_type", 32'(imm_type), 32'd0);
      chk("rst_illegal", {31'd0, illegal}, 32'd0);
      chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
      nrst = 1'b1;
      q.delete();
      stall_m = 0;
      #1;
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      fmt[7'b0000011] = 1; fmt[7'b0010011] = 1; fmt[7'b1100111] = 1;
      fmt[7'b1110011] = 1; fmt[7'b0001111] = 1;
      fmt[7'b0100011] = 2; fmt[7'b1100011] = 3; fmt[7'b1101111] = 4;
      fmt[7'b0110111] = 5; fmt[7'b0010111] = 5; fmt[7'b0110011] = 0;
      foreach (fmt[k]) ops.push_back(k);
      stall_m = 0;
      #2;
      do_reset();

      // Single addi, visible next cycle then gone.
      step(1, 32'h00500093, 32'h100, 1, 0);
      step(0, 32'h0, 32'h0, 1, 0);
      step(0, 32'h0, 32'h0, 1, 0);

      // Back-to-back sw, beq, jal, lui at full throughput.
      step(1, 32'h00112023, 32'h200, 1, 0);
      step(1, 32'h00208463, 32'h204, 1, 0);
      step(1, 32'h000000EF, 32'h208, 1, 0);
      step(1, 32'h12345037, 32'h20C, 1, 0);
      step(0, 32'h0, 32'h0, 1, 0);
      step(0, 32'h0, 32'h0, 1, 0);

      // Back-pressure: third instruction is held by fetch until there is room.
      step(1, 32'h00100113, 32'h300, 0, 0);
      step(1, 32'h00200193, 32'h304, 0, 0);
      step(1, 32'h00300213, 32'h308, 0, 0);
      step(1, 32'h00300213, 32'h308, 0, 0);
      step(1, 32'h00300213, 32'h308, 1, 0);
      step(1, 32'h00300213, 32'h308, 1, 0);
      step(0, 32'h0, 32'h0, 1, 0);
      step(0, 32'h0, 32'h0, 1, 0);
      step(0, 32'h0, 32'h0, 1, 0);

      // Flush while FULL with a push attempt in the same cycle.
      step(1, 32'h00400293, 32'h400, 0, 0);
      step(1, 32'h00500313, 32'h404, 0, 0);
      step(1, 32'h00600393, 32'h408, 0, 1);
      step(0, 32'h0, 32'h0, 1, 0);
      step(0, 32'h0, 32'h0, 1, 0);

      // Illegal opcode, then a legal R-type.
      step(1, 32'hFFFFFFFF, 32'h500, 1, 0);
      step(1, 32'h002081B3, 32'h504, 1, 0);
      step(0, 32'h0, 32'h0, 1, 0);
      step(0, 32'h0, 32'h0, 1, 0);

      // Stall counting over 7 cycles, then asynchronous reset mid-stall.
      do_reset();
      step(1, 32'h00500093, 32'h600, 0, 0);
      for (int i = 0; i < 7; i++) step(0, 32'h0, 32'h0, 0, 0);
`ifdef DECODE_STALL_CNT_EN
      chk("stall_seven", 32'(stall_cnt), 32'd7);
`else
      chk("stall_tied", 32'(stall_cnt), 32'd0);
`endif
      nrst = 1'b0;
      #1;
      chk("async_out_valid", {31'd0, out_valid}, 32'd0);
      chk("async_stall_cnt", 32'(stall_cnt), 32'd0);
      do_reset();

      // Random traffic against the model.
      for (int i = 0; i < 400; i++) begin
         logic [31:0] w;
         w = $urandom;
         if ($urandom_range(0, 9) < 8) w[6:0] = ops[$urandom_range(0, ops.size() - 1)];
         step(($urandom_range(0, 3) != 0), w, $urandom,
              ($urandom_range(0, 2) != 0), ($urandom_range(0, 15) == 0));
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
